// File: rtl/lsu_pkg.sv
// Shared types and the store-lane merge helper for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {MEM_B = 2'd0, MEM_H = 2'd1, MEM_W = 2'd2} mem_size_e;
  typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} lsu_state_e;

  // Replace one byte or half of a word, leaving every other bit untouched.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [1:0]  addr_lo,
                                             input logic        is_half);
    logic [31:0] r;
    r = word;
    if (is_half) begin
      if (addr_lo[1]) r[31:16] = data[15:0];
      else            r[15:0]  = data[15:0];
    end else begin
      r[{addr_lo, 3'b000} +: 8] = data[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half of a loaded word and sign- or zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    data   = '0;
    byte_v = word[{addr_lo, 3'b000} +: 8];
    half_v = addr_lo[1] ? word[31:16] : word[15:0];
    case (mem_size_e'(size))
      MEM_B:   data = is_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      MEM_H:   data = is_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      MEM_W:   data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Word-only data_mem front end: zero-latency loads and SW, two-cycle RMW for SB/SH.
// Handshake: Req_i is held stable while Stall_o=1; Done_o marks the completing cycle.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_SIZE = 256
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        Req_i,
  input  logic        Write_i,
  input  logic [1:0]  Size_i,
  input  logic        Unsigned_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] StoreData_i,
  output logic [31:0] LoadData_o,
  output logic        Done_o,
  output logic        Stall_o,
  output logic        Fault_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic [31:0] MemAddr_o,
  output logic [31:0] MemWData_o,
  input  logic [31:0] MemData_i,
  output logic        State_o
);

  localparam logic [29:0] MEM_WORDS = 30'(MEM_SIZE);

  lsu_state_e  state_q, state_d;
  logic [31:0] rmw_q;
  logic        rmw_load;
  logic        fault;
  logic [31:0] load_data;

  lsu_load_align u_align (
    .word        (MemData_i),
    .addr_lo     (Addr_i[1:0]),
    .size        (Size_i),
    .is_unsigned (Unsigned_i),
    .data        (load_data)
  );

  assign fault = (Size_i == MEM_H && Addr_i[0])
              || (Size_i == MEM_W && Addr_i[1:0] != 2'b00)
              || (Size_i == 2'd3)
              || (Addr_i[31:2] >= MEM_WORDS);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      rmw_q   <= '0;
    end else begin
      state_q <= state_d;
      if (rmw_load) rmw_q <= MemData_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    rmw_load   = 1'b0;
    LoadData_o = '0;
    Done_o     = 1'b0;
    Stall_o    = 1'b0;
    Fault_o    = 1'b0;
    MemRead_o  = 1'b0;
    MemWrite_o = 1'b0;
    MemWData_o = '0;
    MemAddr_o  = Addr_i & ~32'h3;
    State_o    = state_q;
    if (reset_i) begin
      // Reset aborts any pending RMW write and silences every output.
      MemAddr_o = '0;
      State_o   = 1'b0;
      state_d   = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (Req_i) begin
            if (fault) begin
              Fault_o = 1'b1;
              Done_o  = 1'b1;
            end else if (!Write_i) begin
              MemRead_o  = 1'b1;
              Done_o     = 1'b1;
              LoadData_o = load_data;
            end else if (Size_i == MEM_W) begin
              MemWrite_o = 1'b1;
              MemWData_o = StoreData_i;
              Done_o     = 1'b1;
            end else begin
              MemRead_o = 1'b1;
              Stall_o   = 1'b1;
              rmw_load  = 1'b1;
              state_d   = RMW_WR;
            end
          end
        end
        RMW_WR: begin
          // Lane and size come from the live request, held during the stall.
          MemWrite_o = 1'b1;
          MemWData_o = merge_lane(rmw_q, StoreData_i, Addr_i[1:0], Size_i == MEM_H);
          Done_o     = 1'b1;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: attached word memory plus a byte-addressed reference model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int MEM_SIZE = 256;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        Req_i, Write_i, Unsigned_i;
  logic [1:0]  Size_i;
  logic [31:0] Addr_i, StoreData_i;
  logic [31:0] LoadData_o, MemAddr_o, MemWData_o, MemData_i;
  logic        Done_o, Stall_o, Fault_o, MemRead_o, MemWrite_o, State_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem   [0:MEM_SIZE-1];
  logic [7:0]  ref_b [0:MEM_SIZE*4-1];
  logic [31:0] obs_load;

  always #5 clk_i = ~clk_i;

  load_store_unit #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .Req_i       (Req_i),
    .Write_i     (Write_i),
    .Size_i      (Size_i),
    .Unsigned_i  (Unsigned_i),
    .Addr_i      (Addr_i),
    .StoreData_i (StoreData_i),
    .LoadData_o  (LoadData_o),
    .Done_o      (Done_o),
    .Stall_o     (Stall_o),
    .Fault_o     (Fault_o),
    .MemRead_o   (MemRead_o),
    .MemWrite_o  (MemWrite_o),
    .MemAddr_o   (MemAddr_o),
    .MemWData_o  (MemWData_o),
    .MemData_i   (MemData_i),
    .State_o     (State_o)
  );

  // data_mem: combinational read, whole-word write on posedge.
  assign MemData_i = (MemAddr_o[31:10] == 22'd0) ? mem[MemAddr_o[9:2]] : 32'h0;
  always @(posedge clk_i)
    if (MemWrite_o && MemAddr_o[31:10] == 22'd0) mem[MemAddr_o[9:2]] <= MemWData_o;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
  endfunction

  task automatic set_word(input int idx, input logic [31:0] v);
    mem[idx] = v;
    for (int k = 0; k < 4; k++) ref_b[4*idx+k] = v[8*k +: 8];
  endtask

  function automatic logic [31:0] flags();
    return {27'd0, Fault_o, Done_o, Stall_o, MemRead_o, MemWrite_o};
  endfunction

  // Called just after a posedge; returns just after the posedge ending the access.
  task automatic run_op(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] sd);
    bit          bad;
    logic [31:0] exp_load;
    int          nbytes;
    bad = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) || (sz == 2'd3)
       || ((a >> 2) >= MEM_SIZE);
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp_load = '0;
    if (!bad) begin
      for (int k = 0; k < nbytes; k++) exp_load[8*k +: 8] = ref_b[a + k];
      if (!uns && nbytes == 1 && exp_load[7])  exp_load = exp_load - 32'h100;
      if (!uns && nbytes == 2 && exp_load[15]) exp_load = exp_load - 32'h10000;
    end
    Req_i = 1'b1; Write_i = w; Size_i = sz; Unsigned_i = uns; Addr_i = a; StoreData_i = sd;
    @(negedge clk_i);
    check("mem_addr", MemAddr_o, a & ~32'h3);
    if (bad) begin
      check("fault_flags", flags(), 32'b11000);
      check("fault_load", LoadData_o, 32'h0);
    end else if (!w) begin
      check("load_flags", flags(), 32'b01010);
      check("load_data", LoadData_o, exp_load);
      obs_load = LoadData_o;
    end else begin
      for (int k = 0; k < nbytes; k++) ref_b[a + k] = sd[8*k +: 8];
      if (nbytes == 4) begin
        check("sw_flags", flags(), 32'b01001);
        check("sw_wdata", MemWData_o, sd);
      end else begin
        check("rmw1_flags", flags(), 32'b00110);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("rmw2_flags", flags(), 32'b01001);
        check("rmw2_wdata", MemWData_o, ref_word(int'(a >> 2)));
      end
    end
    @(posedge clk_i); #1;
    Req_i = 1'b0;
  endtask

  initial begin
    logic        w, uns;
    logic [1:0]  sz;
    logic [31:0] a, sd;
    int          r;

    for (int i = 0; i < MEM_SIZE; i++) set_word(i, $urandom);
    obs_load = '0;

    // Reset cycle with a request present: everything must be quiet.
    reset_i = 1'b1; Req_i = 1'b1; Write_i = 1'b1; Size_i = 2'd0; Unsigned_i = 1'b0;
    Addr_i = 32'h0; StoreData_i = 32'hFF;
    @(negedge clk_i);
    check("reset_flags", flags(), 32'h0);
    check("reset_wdata", MemWData_o, 32'h0);
    check("reset_addr", MemAddr_o, 32'h0);
    check("reset_load", LoadData_o, 32'h0);
    check("reset_state", {31'd0, State_o}, 32'h0);
    @(posedge clk_i); #1;
    reset_i = 1'b0; Req_i = 1'b0;
    @(negedge clk_i);
    check("idle_flags", flags(), 32'h0);
    @(posedge clk_i); #1;

    // Load extension
    set_word(1, 32'h8899AABB);
    run_op(1'b0, 2'd0, 1'b0, 32'h7, 32'h0); check("lb_0x7", obs_load, 32'hFFFFFF88);
    run_op(1'b0, 2'd0, 1'b1, 32'h7, 32'h0); check("lbu_0x7", obs_load, 32'h00000088);
    run_op(1'b0, 2'd1, 1'b0, 32'h4, 32'h0); check("lh_0x4", obs_load, 32'hFFFFAABB);
    run_op(1'b0, 2'd1, 1'b1, 32'h6, 32'h0); check("lhu_0x6", obs_load, 32'h00008899);

    // SB and SH read-modify-write, then read back
    set_word(2, 32'h11223344);
    run_op(1'b1, 2'd0, 1'b0, 32'hA, 32'hFFFFFFA5); check("sb_word", mem[2], 32'h11A53344);
    set_word(2, 32'h11223344);
    run_op(1'b1, 2'd1, 1'b0, 32'h8, 32'h0000BEEF); check("sh_word", mem[2], 32'h1122BEEF);
    run_op(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);        check("lw_after_sh", obs_load, 32'h1122BEEF);

    // SB right after SW to the same word sees the new word
    run_op(1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678);
    run_op(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000009A); check("sw_then_sb", mem[4], 32'h12349A78);

    // Faults leave memory untouched
    run_op(1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
    run_op(1'b1, 2'd1, 1'b0, 32'h3, 32'hDEAD);
    run_op(1'b1, 2'd2, 1'b0, MEM_SIZE * 4, 32'hCAFEF00D);
    run_op(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
    check("fault_word0", mem[0], ref_word(0));
    check("fault_word1", mem[1], 32'h8899AABB);

    // Reset while in RMW_WR aborts the write
    Req_i = 1'b1; Write_i = 1'b1; Size_i = 2'd0; Unsigned_i = 1'b0;
    Addr_i = 32'h0; StoreData_i = 32'h5A ^ {24'd0, ref_b[0]};
    @(negedge clk_i);
    check("abort_rmw1", flags(), 32'b00110);
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    @(negedge clk_i);
    check("abort_flags", flags(), 32'h0);
    check("abort_wdata", MemWData_o, 32'h0);
    check("abort_state_rst", {31'd0, State_o}, 32'h0);
    @(posedge clk_i); #1;
    reset_i = 1'b0; Req_i = 1'b0;
    @(negedge clk_i);
    check("abort_state", {31'd0, State_o}, 32'h0);
    check("abort_idle", flags(), 32'h0);
    check("abort_nowrite", mem[0], ref_word(0));
    @(posedge clk_i); #1;

    // Random mixed stream
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        Req_i = 1'b0; Write_i = 1'($urandom); Addr_i = $urandom;
        @(negedge clk_i);
        check("rand_idle", flags(), 32'h0);
        @(posedge clk_i); #1;
      end
      w   = 1'($urandom);
      uns = 1'($urandom);
      r   = $urandom_range(0, 15);
      sz  = (r == 15) ? 2'd3 : 2'(r % 3);
      a   = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, MEM_SIZE * 4 - 1));
      if ($urandom_range(0, 1) == 1) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      sd = $urandom;
      run_op(w, sz, uns, a, sd);
    end

    for (int i = 0; i < MEM_SIZE; i++) check($sformatf("final_word_%0d", i), mem[i], ref_word(i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
